// File: rtl/tmds_pkg.sv
// Shared types and symbol tables for the TMDS encoder.
// Define TERC4_EN to add HDMI data-island (TERC4) encoding.
package tmds_pkg;

    typedef logic [9:0]        tmds_sym_t;
    typedef logic [8:0]        qm_t;
    typedef logic signed [4:0] disp_t;

    typedef struct packed {
        qm_t        qm;
        logic       ve;
        logic [1:0] ctrl;
`ifdef TERC4_EN
        logic       island;
        logic [3:0] nib;
`endif
    } stage1_t;

    localparam tmds_sym_t CTRL_TOKEN [4] = '{
        10'b1101010100,
        10'b0010101011,
        10'b0101010100,
        10'b1010101011
    };

`ifdef TERC4_EN
    localparam tmds_sym_t TERC4_TABLE [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };
`endif

endpackage

// File: rtl/count_number_of_ones.sv
// Population count of one byte.
module count_number_of_ones (
    input  logic [7:0] bits_in,
    output logic [3:0] count_out
);

    always_comb begin
        count_out = '0;
        for (int i = 0; i < 8; i++) begin
            count_out = count_out + {3'b000, bits_in[i]};
        end
    end

endmodule

// File: rtl/tmds_channel.sv
// One TMDS lane: transition minimisation, then DC balance / token insertion.
// With TERC4_EN defined, blanking cycles flagged as island emit TERC4 symbols.
module tmds_channel
    import tmds_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic [1:0] control_in,
    input  logic       ve_in,
`ifdef TERC4_EN
    input  logic       island_in,
    input  logic [3:0] terc4_in,
`endif
    output tmds_sym_t  tmds_out
);

    stage1_t   s1_d, s1_q;
    qm_t       qm_d;
    logic      use_xnor;
    logic [3:0] n1_d, n1_q;
    tmds_sym_t sym_d, sym_q;
    disp_t     cnt_d, cnt_q;
    disp_t     n1_s, diff;
    logic      q8;
    logic [7:0] qb;

    localparam disp_t ZERO = 5'sd0;
    localparam disp_t TWO  = 5'sd2;
    localparam disp_t EIGHT = 5'sd8;

    count_number_of_ones u_pc_in (
        .bits_in   (data_in),
        .count_out (n1_d)
    );

    always_comb begin
        use_xnor = (n1_d > 4'd4) || (n1_d == 4'd4 && !data_in[0]);
        qm_d = '0;
        qm_d[0] = data_in[0];
        for (int i = 1; i < 8; i++) begin
            qm_d[i] = use_xnor ? ~(data_in[i] ^ qm_d[i-1])
                               :  (data_in[i] ^ qm_d[i-1]);
        end
        qm_d[8] = ~use_xnor;
        s1_d = '0;
        s1_d.qm = qm_d;
        s1_d.ve = ve_in;
        s1_d.ctrl = control_in;
`ifdef TERC4_EN
        s1_d.island = island_in;
        s1_d.nib = terc4_in;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
        end else begin
            s1_q <= s1_d;
        end
    end

    count_number_of_ones u_pc_qm (
        .bits_in   (s1_q.qm[7:0]),
        .count_out (n1_q)
    );

    // diff = n1 - n0 = 2*n1 - 8, always in [-8, 8]
    always_comb begin
        q8   = s1_q.qm[8];
        qb   = s1_q.qm[7:0];
        n1_s = $signed({1'b0, n1_q});
        diff = n1_s + n1_s - EIGHT;
        sym_d = sym_q;
        cnt_d = cnt_q;
        if (!s1_q.ve) begin
            cnt_d = ZERO;
            sym_d = CTRL_TOKEN[s1_q.ctrl];
`ifdef TERC4_EN
            if (s1_q.island) begin
                sym_d = TERC4_TABLE[s1_q.nib];
            end
`endif
        end else if (cnt_q == ZERO || diff == ZERO) begin
            sym_d = {~q8, q8, q8 ? qb : ~qb};
            cnt_d = cnt_q + (q8 ? diff : -diff);
        end else if ((cnt_q > ZERO && diff > ZERO) ||
                     (cnt_q < ZERO && diff < ZERO)) begin
            sym_d = {1'b1, q8, ~qb};
            cnt_d = cnt_q + (q8 ? TWO : ZERO) - diff;
        end else begin
            sym_d = {1'b0, q8, qb};
            cnt_d = cnt_q - (q8 ? ZERO : TWO) + diff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_q <= CTRL_TOKEN[0];
            cnt_q <= ZERO;
        end else begin
            sym_q <= sym_d;
            cnt_q <= cnt_d;
        end
    end

    assign tmds_out = sym_q;

endmodule

// File: rtl/tmds_encoder.sv
// Multi-lane pipelined TMDS encoder, two-cycle latency, one symbol per lane per clock.
// Define TERC4_EN to expose de_island_in / terc4_in and enable data-island symbols.
module tmds_encoder
    import tmds_pkg::*;
#(
    parameter int CHANNELS = 3
) (
    input  logic                    pixel_clk_in,
    input  logic                    rst_n_in,
    input  logic [8*CHANNELS-1:0]   data_in,
    input  logic [2*CHANNELS-1:0]   control_in,
    input  logic                    ve_in,
`ifdef TERC4_EN
    input  logic                    de_island_in,
    input  logic [4*CHANNELS-1:0]   terc4_in,
`endif
    output logic [10*CHANNELS-1:0]  tmds_out
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        tmds_channel u_ch (
            .clk        (pixel_clk_in),
            .rst_n      (rst_n_in),
            .data_in    (data_in[8*c +: 8]),
            .control_in (control_in[2*c +: 2]),
            .ve_in      (ve_in),
`ifdef TERC4_EN
            .island_in  (de_island_in),
            .terc4_in   (terc4_in[4*c +: 4]),
`endif
            .tmds_out   (tmds_out[10*c +: 10])
        );
    end

endmodule

// File: tb/tb_tmds_encoder.sv
// Bench for tmds_encoder: integer reference model plus directed literal checks.
// Covers the TERC4_EN build when that macro is defined.
module tb_tmds_encoder;

    localparam int CH = 3;

    localparam logic [9:0] CTOK [4] = '{
        10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
    };
`ifdef TERC4_EN
    localparam logic [9:0] TERC [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] data;
    logic [5:0]  ctrl;
    logic        ve;
`ifdef TERC4_EN
    logic        island;
    logic [11:0] terc;
`endif
    logic [29:0] tmds;

    int n_total = 0;
    int n_pass  = 0;

    logic [9:0] exp_out [CH];
    logic [9:0] pend    [CH];
    int         mcnt    [CH];

    always #5 clk = ~clk;

    tmds_encoder #(.CHANNELS(CH)) dut (
        .pixel_clk_in (clk),
        .rst_n_in     (rst_n),
        .data_in      (data),
        .control_in   (ctrl),
        .ve_in        (ve),
`ifdef TERC4_EN
        .de_island_in (island),
        .terc4_in     (terc),
`endif
        .tmds_out     (tmds)
    );

    task automatic check(input string name, input logic [9:0] act,
                         input logic [9:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, req);
    endtask

    task automatic lit(input string name, input int lane,
                       input logic [9:0] req);
        check(name, tmds[lane*10 +: 10], req);
    endtask

    // DVI 1.0 encoding of one byte with plain integer disparity bookkeeping
    function automatic logic [9:0] ref_enc(input logic [7:0] d, input int ci,
                                           output int co);
        int n, n1, n0;
        bit xn;
        logic [8:0] qm;
        logic [9:0] s;
        n = 0;
        for (int i = 0; i < 8; i++) n += int'(d[i]);
        xn = (n > 4) || (n == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = xn ? !(d[i] ^ qm[i-1]) : (d[i] ^ qm[i-1]);
        qm[8] = !xn;
        n1 = 0;
        for (int i = 0; i < 8; i++) n1 += int'(qm[i]);
        n0 = 8 - n1;
        if (ci == 0 || n1 == n0) begin
            s  = {!qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            co = ci + (qm[8] ? n1 - n0 : n0 - n1);
        end else if ((ci > 0 && n1 > n0) || (ci < 0 && n0 > n1)) begin
            s  = {1'b1, qm[8], ~qm[7:0]};
            co = ci + 2 * int'(qm[8]) + n0 - n1;
        end else begin
            s  = {1'b0, qm[8], qm[7:0]};
            co = ci - 2 * (1 - int'(qm[8])) + n1 - n0;
        end
        return s;
    endfunction

    // model: symbol chosen at the sampling edge, visible one edge later
    initial forever begin
        @(posedge clk or negedge rst_n);
        for (int c = 0; c < CH; c++) begin
            if (!rst_n) begin
                exp_out[c] = CTOK[0];
                pend[c]    = CTOK[0];
                mcnt[c]    = 0;
            end else begin
                int nc;
                exp_out[c] = pend[c];
                if (ve) begin
                    pend[c] = ref_enc(data[c*8 +: 8], mcnt[c], nc);
                    mcnt[c] = nc;
                end else begin
                    pend[c] = CTOK[ctrl[c*2 +: 2]];
`ifdef TERC4_EN
                    if (island) pend[c] = TERC[terc[c*4 +: 4]];
`endif
                    mcnt[c] = 0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        for (int c = 0; c < CH; c++)
            check($sformatf("model_lane%0d", c), tmds[c*10 +: 10], exp_out[c]);
    end

    task automatic apply(input logic v, input logic [23:0] d,
                         input logic [5:0] c);
        @(negedge clk);
        ve   = v;
        data = d;
        ctrl = c;
    endtask

    initial begin
        logic [31:0] r;
        ve = 1'b0; data = '0; ctrl = '0;
`ifdef TERC4_EN
        island = 1'b0; terc = '0;
`endif
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int c = 0; c < CH; c++) lit("reset_token", c, 10'b1101010100);

        apply(1'b0, 24'h0, 6'b000001);
        rst_n = 1'b1;
        apply(1'b0, 24'h0, 6'b000001);
        lit("pre_valid", 0, 10'b1101010100);
        apply(1'b0, 24'h0, 6'b000001);
        lit("ctrl01", 0, 10'b0010101011);

        apply(1'b1, 24'h10FF00, 6'b0);
        apply(1'b1, 24'h10FF00, 6'b0);
        apply(1'b0, 24'h0, 6'b0);
        lit("zero_cnt0", 0, 10'b0100000000);
        lit("ff_xnor",   1, 10'b1000000000);
        lit("x10_lane2", 2, 10'b0111110000);
        apply(1'b1, 24'h10FF00, 6'b0);
        lit("zero_cntm8", 0, 10'b1111111111);
        lit("ff_cntm8",   1, 10'b0011111111);
        apply(1'b0, 24'h0, 6'b0);
        lit("blank_tok", 0, 10'b1101010100);
        apply(1'b0, 24'h0, 6'b0);
        lit("blank_clears", 0, 10'b0100000000);

        apply(1'b1, 24'hA5C31E, 6'b0);
        apply(1'b1, 24'h7F0180, 6'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int c = 0; c < CH; c++) lit("async_rst", c, 10'b1101010100);
        apply(1'b0, 24'h0, 6'b100111);
        rst_n = 1'b1;
        apply(1'b0, 24'h0, 6'b100111);
        apply(1'b0, 24'h0, 6'b0);
        lit("ctrl11", 0, 10'b1010101011);
        lit("ctrl10", 2, 10'b0101010100);

`ifdef TERC4_EN
        apply(1'b0, 24'h0, 6'b0);
        island = 1'b1; terc = 12'h3F0;
        apply(1'b1, 24'h0, 6'b0);
        apply(1'b0, 24'h0, 6'b0);
        island = 1'b0;
        lit("terc4_0", 0, 10'b1010011100);
        lit("terc4_f", 1, 10'b1011000011);
        apply(1'b0, 24'h0, 6'b0);
        lit("video_wins", 0, 10'b0100000000);
`endif

        for (int i = 0; i < 10000; i++) begin
            r = $urandom;
            apply(r[31:29] != 3'd0, r[23:0], r[28:24 - 0] == 5'd0 ? 6'h0 : r[29:24]);
`ifdef TERC4_EN
            r = $urandom;
            island = r[12];
            terc = r[11:0];
`endif
        end
        apply(1'b0, 24'h0, 6'b0);
        apply(1'b0, 24'h0, 6'b0);
        apply(1'b0, 24'h0, 6'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
